// File: rtl/overcooked_pkg.sv
// Shared types and constants for the kitchen game: game states, facing
// directions, tile codes, grid dimensions and the movement FSM encoding.
package overcooked_pkg;

  localparam int unsigned N_GRID_COLS = 13;
  localparam int unsigned N_GRID_ROWS = 8;
  localparam int unsigned POS_W       = 9;

  typedef enum logic [2:0] {
    GS_MENU    = 3'd0,
    GS_PLAYING = 3'd1,
    GS_PAUSED  = 3'd2,
    GS_OVER    = 3'd3
  } game_state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef logic [3:0] tile_code_t;

  localparam tile_code_t TILE_FLOOR   = 4'd0;
  localparam tile_code_t TILE_COUNTER = 4'd1;
  localparam tile_code_t TILE_STOVE   = 4'd2;
  localparam tile_code_t TILE_CRATE   = 4'd3;
  localparam tile_code_t TILE_WALL    = 4'd15;

  typedef logic [N_GRID_ROWS-1:0][N_GRID_COLS-1:0][3:0] grid_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHK_X_A = 3'd1,
    S_CHK_X_B = 3'd2,
    S_CHK_Y_A = 3'd3,
    S_CHK_Y_B = 3'd4,
    S_DONE    = 3'd5
  } move_state_e;

endpackage

// File: rtl/player_move_if.sv
// Per-player movement bus: frame sync, buttons, game state and grid in;
// registered location, facing and status out.
interface player_move_if;
  import overcooked_pkg::*;

  logic                 vsync;
  logic                 left;
  logic                 right;
  logic                 up;
  logic                 down;
  logic [2:0]           game_state;
  grid_t                object_grid;
  logic [POS_W-1:0]     player_loc_x;
  logic [POS_W-1:0]     player_loc_y;
  logic [1:0]           player_direction;
  logic                 player_moving;
  logic                 move_done;

  modport master (
    output vsync, left, right, up, down, game_state, object_grid,
    input  player_loc_x, player_loc_y, player_direction, player_moving, move_done
  );

  modport slave (
    input  vsync, left, right, up, down, game_state, object_grid,
    output player_loc_x, player_loc_y, player_direction, player_moving, move_done
  );
endinterface

// File: rtl/tile_lookup.sv
// Combinational pixel-to-tile lookup: returns the tile code under (px, py)
// and whether it blocks movement. Off-grid pixels read as wall.
module tile_lookup
  import overcooked_pkg::*;
#(
  parameter int unsigned TILE_SIZE = 32
) (
  input  logic [POS_W-1:0] px,
  input  logic [POS_W-1:0] py,
  input  grid_t            object_grid,
  output tile_code_t       tile_code_c,
  output logic             blocked_c
);

  localparam int unsigned SHIFT = $clog2(TILE_SIZE);
  localparam int unsigned COL_W = $clog2(N_GRID_COLS);
  localparam int unsigned ROW_W = $clog2(N_GRID_ROWS);

  logic [POS_W-1:0] col_full;
  logic [POS_W-1:0] row_full;
  logic [COL_W-1:0] col_idx;
  logic [ROW_W-1:0] row_idx;

  assign col_full = px >> SHIFT;
  assign row_full = py >> SHIFT;
  assign col_idx  = COL_W'(col_full);
  assign row_idx  = ROW_W'(row_full);

  // Select the tile, treating anything outside the grid as solid
  always_comb begin
    tile_code_c = TILE_WALL;
    if ((col_full < POS_W'(N_GRID_COLS)) && (row_full < POS_W'(N_GRID_ROWS))) begin
      tile_code_c = object_grid[row_idx][col_idx];
    end
    blocked_c = (tile_code_c != TILE_FLOOR);
  end

endmodule

// File: rtl/player_move.sv
// Per-player movement: once per frame turns held buttons into a clamped,
// collision-checked pixel position and a facing direction. X is resolved
// first, then Y against the updated X, so diagonal moves slide along walls.
module player_move
  import overcooked_pkg::*;
#(
  parameter int unsigned TILE_SIZE   = 32,
  parameter int unsigned PLAYER_SIZE = 32,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned GRID_COLS   = N_GRID_COLS,
  parameter int unsigned GRID_ROWS   = N_GRID_ROWS,
  parameter int unsigned SPAWN_X     = 64,
  parameter int unsigned SPAWN_Y     = 64
) (
  input logic          clk_in,
  input logic          reset,
  player_move_if.slave pm
);

  localparam int unsigned X_MAX = GRID_COLS * TILE_SIZE - PLAYER_SIZE;
  localparam int unsigned Y_MAX = GRID_ROWS * TILE_SIZE - PLAYER_SIZE;
  localparam int unsigned EXT_W = POS_W + 1;

  move_state_e      state_q, state_d;
  logic             vsync_q, vsync_qq;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  dir_e             dir_q, dir_d;
  logic             moving_q, moving_d;
  logic             done_q, done_d;
  logic             x_neg_q, x_neg_d, x_pos_q, x_pos_d;
  logic             y_neg_q, y_neg_d, y_pos_q, y_pos_d;
  logic             blk_q, blk_d;
  logic             x_chg_q, x_chg_d;

  logic             tick_c;
  logic [POS_W-1:0] cand_x, cand_y, lead_x, lead_y;
  logic [POS_W-1:0] qx, qy;
  logic             lookup_blocked;
  logic             x_commit, y_commit;
  tile_code_t       unused_tile_code;

  // One step of SPEED in the requested sense, signed so a step below 0 clamps
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                input logic             neg,
                                                input logic [EXT_W-1:0] max_pos);
    logic signed [EXT_W-1:0] cand;
    if (neg) cand = $signed({1'b0, pos}) - $signed(EXT_W'(SPEED));
    else     cand = $signed({1'b0, pos}) + $signed(EXT_W'(SPEED));
    if (cand < $signed(EXT_W'(0)))       step_pos = '0;
    else if (cand > $signed(max_pos))    step_pos = POS_W'(max_pos);
    else                                 step_pos = POS_W'(cand);
  endfunction

  assign tick_c = vsync_q & ~vsync_qq;

  // Tile code is consumed by the action block; movement only needs the flag
  tile_lookup #(.TILE_SIZE(TILE_SIZE)) u_tile_lookup (
    .px          (qx),
    .py          (qy),
    .object_grid (pm.object_grid),
    .tile_code_c (unused_tile_code),
    .blocked_c   (lookup_blocked)
  );

  // Candidate positions, leading edges and the tile probed this cycle
  always_comb begin
    cand_x = step_pos(x_q, x_neg_q, EXT_W'(X_MAX));
    cand_y = step_pos(y_q, y_neg_q, EXT_W'(Y_MAX));
    lead_x = x_neg_q ? cand_x : cand_x + POS_W'(PLAYER_SIZE - 1);
    lead_y = y_neg_q ? cand_y : cand_y + POS_W'(PLAYER_SIZE - 1);
    qx     = x_q;
    qy     = y_q;
    case (state_q)
      S_CHK_X_A: begin qx = lead_x; qy = y_q; end
      S_CHK_X_B: begin qx = lead_x; qy = y_q + POS_W'(PLAYER_SIZE - 1); end
      S_CHK_Y_A: begin qx = x_q;    qy = lead_y; end
      S_CHK_Y_B: begin qx = x_q + POS_W'(PLAYER_SIZE - 1); qy = lead_y; end
      default:   begin qx = x_q;    qy = y_q; end
    endcase
  end

  assign x_commit = (x_neg_q | x_pos_q) & ~blk_q & ~lookup_blocked;
  assign y_commit = (y_neg_q | y_pos_q) & ~blk_q & ~lookup_blocked;

  // Next-state and datapath updates for the frame move sequence
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    moving_d = moving_q;
    done_d   = 1'b0;
    x_neg_d  = x_neg_q;
    x_pos_d  = x_pos_q;
    y_neg_d  = y_neg_q;
    y_pos_d  = y_pos_q;
    blk_d    = blk_q;
    x_chg_d  = x_chg_q;

    if (pm.game_state == GS_MENU) begin
      state_d  = S_IDLE;
      x_d      = POS_W'(SPAWN_X);
      y_d      = POS_W'(SPAWN_Y);
      dir_d    = DIR_DOWN;
      moving_d = 1'b0;
    end else if (pm.game_state == GS_PLAYING) begin
      case (state_q)
        S_IDLE: begin
          if (tick_c) begin
            state_d = S_CHK_X_A;
            if (pm.up)         dir_d = DIR_UP;
            else if (pm.down)  dir_d = DIR_DOWN;
            else if (pm.left)  dir_d = DIR_LEFT;
            else if (pm.right) dir_d = DIR_RIGHT;
            x_neg_d = pm.left  & ~pm.right;
            x_pos_d = pm.right & ~pm.left;
            y_neg_d = pm.up    & ~pm.down;
            y_pos_d = pm.down  & ~pm.up;
            x_chg_d = 1'b0;
          end
        end
        S_CHK_X_A: begin
          blk_d   = lookup_blocked;
          state_d = S_CHK_X_B;
        end
        S_CHK_X_B: begin
          if (x_commit) x_d = cand_x;
          x_chg_d = x_commit & (cand_x != x_q);
          state_d = S_CHK_Y_A;
        end
        S_CHK_Y_A: begin
          blk_d   = lookup_blocked;
          state_d = S_CHK_Y_B;
        end
        S_CHK_Y_B: begin
          if (y_commit) y_d = cand_y;
          moving_d = x_chg_q | (y_commit & (cand_y != y_q));
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      x_q      <= POS_W'(SPAWN_X);
      y_q      <= POS_W'(SPAWN_Y);
      dir_q    <= DIR_DOWN;
      moving_q <= 1'b0;
      done_q   <= 1'b0;
      x_neg_q  <= 1'b0;
      x_pos_q  <= 1'b0;
      y_neg_q  <= 1'b0;
      y_pos_q  <= 1'b0;
      blk_q    <= 1'b0;
      x_chg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= pm.vsync;
      vsync_qq <= vsync_q;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      done_q   <= done_d;
      x_neg_q  <= x_neg_d;
      x_pos_q  <= x_pos_d;
      y_neg_q  <= y_neg_d;
      y_pos_q  <= y_pos_d;
      blk_q    <= blk_d;
      x_chg_q  <= x_chg_d;
    end
  end

  assign pm.player_loc_x     = x_q;
  assign pm.player_loc_y     = y_q;
  assign pm.player_direction = dir_q;
  assign pm.player_moving    = moving_q;
  assign pm.move_done        = done_q;

endmodule

// File: tb/tb_player_move.sv
// Scoreboard bench for player_move: frames issued in play push the expected
// end-of-frame result; a monitor pops and compares on every move_done.
module tb_player_move;
  import overcooked_pkg::*;

  localparam int TS    = 32;
  localparam int PS    = 32;
  localparam int SPEED = 2;
  localparam int XMAX  = 13 * TS - PS;
  localparam int YMAX  = 8 * TS - PS;

  typedef struct {
    int x;
    int y;
    int dir;
    bit moving;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset;
  always #5 clk_in = ~clk_in;

  player_move_if pm();

  player_move dut (
    .clk_in (clk_in),
    .reset  (reset),
    .pm     (pm)
  );

  exp_t  exp_q[$];
  exp_t  mon_e;
  grid_t grid;
  int    n_cmp = 0;
  int    n_err = 0;
  int    mx, my, mdir;

  function automatic void cmp(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic bit free_at(int px, int py);
    return grid[py / TS][px / TS] == TILE_FLOOR;
  endfunction

  // Reference: one frame of movement computed from the game rules directly
  task automatic model_push(input bit l, input bit r, input bit u, input bit d);
    exp_t e;
    int dx, dy, c, lead, nx, ny;
    if (u)      mdir = 0;
    else if (d) mdir = 1;
    else if (l) mdir = 2;
    else if (r) mdir = 3;
    dx = int'(r) - int'(l);
    dy = int'(d) - int'(u);
    nx = mx;
    if (dx != 0) begin
      c = mx + dx * SPEED;
      if (c < 0) c = 0;
      if (c > XMAX) c = XMAX;
      lead = (dx < 0) ? c : c + PS - 1;
      if (free_at(lead, my) && free_at(lead, my + PS - 1)) nx = c;
    end
    ny = my;
    if (dy != 0) begin
      c = my + dy * SPEED;
      if (c < 0) c = 0;
      if (c > YMAX) c = YMAX;
      lead = (dy < 0) ? c : c + PS - 1;
      if (free_at(nx, lead) && free_at(nx + PS - 1, lead)) ny = c;
    end
    e.moving = (nx != mx) || (ny != my);
    mx = nx;
    my = ny;
    e.x = mx;
    e.y = my;
    e.dir = mdir;
    exp_q.push_back(e);
  endtask

  task automatic set_buttons(input bit l, input bit r, input bit u, input bit d);
    pm.left = l; pm.right = r; pm.up = u; pm.down = d;
  endtask

  task automatic frame(input bit l, input bit r, input bit u, input bit d, input bit expect_move);
    set_buttons(l, r, u, d);
    if (expect_move) model_push(l, r, u, d);
    pm.vsync = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 pm.vsync = 1'b0;
    repeat (8) @(posedge clk_in);
    #1;
  endtask

  task automatic frames(input int n, input bit l, input bit r, input bit u, input bit d);
    for (int i = 0; i < n; i++) frame(l, r, u, d, 1'b1);
  endtask

  task automatic model_spawn();
    mx = 64; my = 64; mdir = 1;
  endtask

  task automatic random_grid();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 13; c++) begin
        if ($urandom_range(0, 4) == 0) begin
          case ($urandom_range(0, 2))
            0:       grid[r][c] = TILE_COUNTER;
            1:       grid[r][c] = TILE_STOVE;
            default: grid[r][c] = TILE_CRATE;
          endcase
        end else begin
          grid[r][c] = TILE_FLOOR;
        end
      end
    end
    pm.object_grid = grid;
  endtask

  // Monitor: every move_done must match the oldest outstanding expectation
  always @(negedge clk_in) begin
    if (!reset && pm.move_done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_move_done: got 1 required 0 (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        cmp("sb_x", int'(pm.player_loc_x), mon_e.x);
        cmp("sb_y", int'(pm.player_loc_y), mon_e.y);
        cmp("sb_dir", int'(pm.player_direction), mon_e.dir);
        cmp("sb_moving", int'(pm.player_moving), int'(mon_e.moving));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0] b;
    reset = 1'b1;
    pm.vsync = 1'b0;
    set_buttons(0, 0, 0, 0);
    pm.game_state = GS_PLAYING;
    grid = '0;
    pm.object_grid = grid;
    model_spawn();
    repeat (3) @(posedge clk_in);
    #1;
    cmp("reset_x", int'(pm.player_loc_x), 64);
    cmp("reset_y", int'(pm.player_loc_y), 64);
    cmp("reset_dir", int'(pm.player_direction), 1);
    cmp("reset_done", int'(pm.move_done), 0);
    cmp("reset_moving", int'(pm.player_moving), 0);
    reset = 1'b0;
    @(posedge clk_in);
    #1;

    // Walk right on an empty grid
    frames(3, 0, 1, 0, 0);
    cmp("right3_x", int'(pm.player_loc_x), 70);
    cmp("right3_y", int'(pm.player_loc_y), 64);
    cmp("right3_dir", int'(pm.player_direction), 3);

    // Counter at row 2 col 4 stops the player at x=96
    grid[2][4] = TILE_COUNTER;
    pm.object_grid = grid;
    frames(13, 0, 1, 0, 0);
    cmp("approach_x", int'(pm.player_loc_x), 96);
    frames(1, 0, 1, 0, 0);
    cmp("blocked_x", int'(pm.player_loc_x), 96);
    cmp("blocked_dir", int'(pm.player_direction), 3);
    cmp("blocked_moving", int'(pm.player_moving), 0);

    // Left+up into the corner, clamping without wrap
    frames(48, 1, 0, 1, 0);
    cmp("corner_x", int'(pm.player_loc_x), 0);
    cmp("corner_y", int'(pm.player_loc_y), 0);
    cmp("corner_dir", int'(pm.player_direction), 0);
    frames(1, 1, 0, 1, 0);
    cmp("clamp_moving", int'(pm.player_moving), 0);

    // Opposing buttons cancel movement but still turn the player
    frames(1, 1, 1, 0, 0);
    cmp("cancel_x", int'(pm.player_loc_x), 0);
    cmp("cancel_dir", int'(pm.player_direction), 2);

    // Diagonal against the counter slides along y
    frames(48, 0, 1, 0, 0);
    frames(20, 0, 0, 0, 1);
    frames(1, 0, 1, 0, 1);
    cmp("slide_x", int'(pm.player_loc_x), 96);
    cmp("slide_y", int'(pm.player_loc_y), 42);
    cmp("slide_moving", int'(pm.player_moving), 1);
    cmp("slide_dir", int'(pm.player_direction), 1);

    // Paused: ticks are ignored
    pm.game_state = GS_PAUSED;
    for (int i = 0; i < 5; i++) frame(0, 1, 0, 0, 1'b0);
    cmp("paused_x", int'(pm.player_loc_x), 96);
    cmp("paused_y", int'(pm.player_loc_y), 42);
    pm.game_state = GS_PLAYING;

    // Reset mid-sequence, after x has already moved at T+3
    set_buttons(1, 0, 0, 0);
    pm.vsync = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 pm.vsync = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    cmp("midmove_x_t3", int'(pm.player_loc_x), 94);
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    cmp("midreset_x", int'(pm.player_loc_x), 64);
    cmp("midreset_y", int'(pm.player_loc_y), 64);
    cmp("midreset_dir", int'(pm.player_direction), 1);
    cmp("midreset_done", int'(pm.move_done), 0);
    @(posedge clk_in);
    #1 reset = 1'b0;
    set_buttons(0, 0, 0, 0);
    model_spawn();
    repeat (10) @(posedge clk_in);
    #1;

    // Menu snaps back to spawn
    frames(2, 0, 1, 0, 0);
    cmp("premenu_x", int'(pm.player_loc_x), 68);
    pm.game_state = GS_MENU;
    repeat (2) @(posedge clk_in);
    #1;
    cmp("menu_x", int'(pm.player_loc_x), 64);
    cmp("menu_y", int'(pm.player_loc_y), 64);
    cmp("menu_dir", int'(pm.player_direction), 1);
    cmp("menu_moving", int'(pm.player_moving), 0);
    pm.game_state = GS_PLAYING;
    model_spawn();
    frames(1, 0, 0, 0, 0);

    // Random buttons over random kitchens, with occasional paused frames
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) random_grid();
      b = 4'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        pm.game_state = GS_OVER;
        frame(b[0], b[1], b[2], b[3], 1'b0);
        pm.game_state = GS_PLAYING;
      end else begin
        frame(b[0], b[1], b[2], b[3], 1'b1);
      end
    end

    repeat (5) @(posedge clk_in);
    #1;
    cmp("pending_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/player_move.md
Name: player_move

Overview:
- Per-player movement stage directly upstream of the action/interaction block.
- Converts held direction buttons into a registered pixel location and facing direction, once per video frame (vsync rising edge).
- Resolves collisions against the live object grid so players cannot walk through counters, stoves or crates.
- player_loc_x/y and player_direction feed the action block unchanged. One instance per player.

Parameters:
- TILE_SIZE, 32, tile edge in pixels; power of two; tile index = coordinate >> log2(TILE_SIZE).
- PLAYER_SIZE, 32, player bounding-box edge in pixels; must be <= TILE_SIZE, so an edge spans at most two tiles.
- SPEED, 2, pixels moved per frame per axis; must be < TILE_SIZE.
- GRID_COLS, 13, grid width in tiles.
- GRID_ROWS, 8, grid height in tiles.
- SPAWN_X, 64, reset/menu x position (pixels).
- SPAWN_Y, 64, reset/menu y position (pixels).

Ports:
- clk_in  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- vsync  input  1  frame sync, synchronous to clk_in
- left, right, up, down  input  1 each  held button levels (debounced upstream)
- game_state  input  3  global game state (encoding in package)
- object_grid  input  [GRID_ROWS-1:0][GRID_COLS-1:0][3:0]  tile codes, indexed [row][col]
- player_loc_x  output  9  top-left x of player box, pixels
- player_loc_y  output  9  top-left y of player box, pixels
- player_direction  output  2  facing direction: 0 up, 1 down, 2 left, 3 right
- player_moving  output  1  1 if position changed in the last frame update
- move_done  output  1  one-cycle pulse when a frame update completes

Behaviour:
- Reset (async, active-high): x=SPAWN_X, y=SPAWN_Y, direction=1 (down), player_moving=0, move_done=0, FSM=IDLE.
- Frame tick: vsync is registered; tick = registered vsync high and its previous value low. Tick is detected in cycle T.
- A tick is acted on only in IDLE with game_state==GS_PLAYING. Otherwise it is ignored: no move_done, no state change.
- game_state==GS_MENU: x/y forced to SPAWN, direction=down, player_moving=0, FSM forced to IDLE, every cycle.
- GS_PAUSED and GS_OVER: all outputs hold.
- Direction update at T+1, with priority up > down > left > right. Direction is updated even if the move is blocked; no button pressed leaves it unchanged.
- Axis intent: dx = right − left, dy = down − up. Opposite buttons pressed together give 0 on that axis.
- FSM sequence:
  - IDLE → CHK_X_A (T+1) → CHK_X_B (T+2) → CHK_Y_A (T+3) → CHK_Y_B (T+4) → DONE (T+5) → IDLE.
  - CHK_*_A checks the leading-edge tile at the lower perpendicular coordinate; CHK_*_B checks the tile at perpendicular coordinate + PLAYER_SIZE − 1. Each stage registers a blocked flag.
  - X is committed at the end of CHK_X_B (visible at T+3). Y is checked using the updated x and committed at the end of CHK_Y_B (visible at T+5).
  - move_done is high during DONE only. player_moving is updated in DONE.
  - An axis with zero intent skips commit but still walks through its states, so latency is fixed.
- Candidate position and leading edge:
  - Moving left/up: cand = pos − SPEED. Leading edge = cand.
  - Moving right/down: cand = pos + SPEED. Leading edge = cand + PLAYER_SIZE − 1.
- Clamping (before the tile check): x to [0, GRID_COLS*TILE_SIZE − PLAYER_SIZE]; y to [0, GRID_ROWS*TILE_SIZE − PLAYER_SIZE].
  - Subtraction uses 10-bit signed arithmetic; a negative result clamps to 0 and never wraps.
- Blocking: a tile is blocked if its code != TILE_FLOOR. A blocked axis keeps its old position; there is no partial step.
- Sliding: x and y are resolved independently, so a diagonal move against a wall slides along it.
- object_grid is sampled live in each check cycle. Grid writes mid-sequence are allowed; each check uses the value present in its own cycle.
- Reset asserted mid-sequence aborts immediately to reset values; no move_done.

Decomposition:
- Shared package overcooked_pkg holds:
  - game_state codes: GS_MENU=0, GS_PLAYING=1, GS_PAUSED=2, GS_OVER=3.
  - Direction enum: DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
  - Tile codes, including TILE_FLOOR=0.
  - Grid dimension constants.
- One natural sub-module, tile_lookup: combinational pixel (x,y) → grid row/col → 4-bit tile code plus blocked flag. It is reused by the action block.

Test Plan:
- Reset with empty grid → x=64, y=64, dir=1, move_done=0. Hold right for 3 ticks, SPEED=2 → x=70, y=64, dir=3; move_done pulses at T+5 of each tick.
- Counter at grid[2][4], player at (94,64) holding right → tick 1: x=96; tick 2: leading edge 129 (col 4) is blocked, so x stays 96, dir=3, player_moving=0.
- Player at (1,0) holding left+up → x=0, y=0 (clamped, no wrap), dir=0. Left+right together → x unchanged, dir=2.
- Counter at grid[2][4], player at (96,40) holding right+down → x blocked at 96, y slides to 42, player_moving=1.
- game_state=GS_PAUSED holding right for 5 ticks → no change, no move_done. GS_MENU → (64,64), dir=1.
- Assert reset at T+3 mid-move → outputs at spawn on the next cycle; no move_done for that frame.
